// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the configurable UART transmitter and receiver:
// parity-mode encodings, the transmitter state enum and the default
// oversampling ratio (ticks per bit).
package uart_pkg;

  localparam int DEFAULT_OSR = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
// Runtime-configurable UART transmitter. One frame is sent per accepted
// start request: start bit, 1..DBIT_MAX data bits (LSB first), optional
// parity bit, then one or two stop bits. Every bit lasts OSR oversampling
// ticks. The frame configuration is captured when the start is accepted,
// so the config inputs may change freely while a frame is in flight.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_s_tick    one-cycle oversampling tick from the baud generator
//   i_tx_start  frame request, only looked at while idle
//   i_din       data word, LSB sent first
//   i_nbits     data bits minus one (clamped to DBIT_MAX-1)
//   i_parity    00 none, 01 even, 10 odd, 11 mark
//   i_stop2     0: one stop bit, 1: two stop bits
//   o_tx        registered serial line, idle high
//   o_busy      high from start acceptance until the frame ends
//   o_tx_done   one-cycle pulse on the frame's terminating tick
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX = 8,
  parameter int OSR      = DEFAULT_OSR,
  parameter int NB_W     = $clog2(DBIT_MAX)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_s_tick,
  input  logic                i_tx_start,
  input  logic [DBIT_MAX-1:0] i_din,
  input  logic [NB_W-1:0]     i_nbits,
  input  logic [1:0]          i_parity,
  input  logic                i_stop2,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_tx_done
);

  localparam int TW = $clog2(2 * OSR);
  localparam int BW = NB_W + 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(OSR - 1);
  localparam logic [TW-1:0] TICK_LAST2 = TW'(2 * OSR - 1);
  localparam logic [BW-1:0] NB_MAX     = BW'(DBIT_MAX - 1);

  tx_state_t state, state_n;

  logic [TW-1:0]       tick_cnt, tick_n;
  logic [BW-1:0]       bit_cnt, bit_n;
  logic [DBIT_MAX-1:0] shift, shift_n;
  logic [BW-1:0]       nbits_q, nbits_n;
  logic [1:0]          parity_q, parity_n;
  logic                stop2_q, stop2_n;
  logic                par_bit, par_bit_n;
  logic                tx_q, tx_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;

  logic [BW-1:0]       nbits_eff;
  logic [DBIT_MAX-1:0] din_mask;
  logic [DBIT_MAX-1:0] din_masked;
  logic [TW-1:0]       stop_last;

  // Clamp the requested length and keep only the bits that will actually be
  // sent, so the parity covers exactly the transmitted data.
  always_comb begin
    nbits_eff = ({1'b0, i_nbits} >= NB_MAX) ? NB_MAX : {1'b0, i_nbits};
    din_mask  = '0;
    for (int i = 0; i < DBIT_MAX; i++) begin
      din_mask[i] = (BW'(i) <= nbits_eff);
    end
    din_masked = i_din & din_mask;
  end

  assign stop_last = stop2_q ? TICK_LAST2 : TICK_LAST;

  // Next-state and registered-output logic. o_tx/o_busy/o_tx_done are
  // computed here for the coming edge so that the line reacts on the same
  // edge as the state change (start acceptance, terminating tick).
  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    shift_n   = shift;
    nbits_n   = nbits_q;
    parity_n  = parity_q;
    stop2_n   = stop2_q;
    par_bit_n = par_bit;
    tx_n      = tx_q;
    busy_n    = busy_q;
    done_n    = 1'b0;

    case (state)
      TX_IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        // A tick arriving together with the start is deliberately not counted.
        if (i_tx_start) begin
          shift_n  = din_masked;
          nbits_n  = nbits_eff;
          parity_n = i_parity;
          stop2_n  = i_stop2;
          if (i_parity == PAR_MARK) begin
            par_bit_n = 1'b1;
          end else if (i_parity == PAR_ODD) begin
            par_bit_n = ~(^din_masked);
          end else begin
            par_bit_n = ^din_masked;
          end
          tick_n  = '0;
          bit_n   = '0;
          state_n = TX_START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end

      TX_START: begin
        if (i_s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            state_n = TX_DATA;
            tx_n    = shift[0];
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end

      TX_DATA: begin
        if (i_s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            shift_n = shift >> 1;
            if (bit_cnt == nbits_q) begin
              bit_n = '0;
              if (parity_q != PAR_NONE) begin
                state_n = TX_PARITY;
                tx_n    = par_bit;
              end else begin
                state_n = TX_STOP;
                tx_n    = 1'b1;
              end
            end else begin
              bit_n = bit_cnt + BW'(1);
              tx_n  = shift_n[0];
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end

      TX_PARITY: begin
        if (i_s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            state_n = TX_STOP;
            tx_n    = 1'b1;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end

      TX_STOP: begin
        // Two stop bits are one continuous high period of 2*OSR ticks.
        tx_n = 1'b1;
        if (i_s_tick) begin
          if (tick_cnt == stop_last) begin
            tick_n  = '0;
            state_n = TX_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end

      default: begin
        state_n = TX_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= TX_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      nbits_q  <= '0;
      parity_q <= PAR_NONE;
      stop2_q  <= 1'b0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      nbits_q  <= nbits_n;
      parity_q <= parity_n;
      stop2_q  <= stop2_n;
      par_bit  <= par_bit_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  assign o_tx      = tx_q;
  assign o_busy    = busy_q;
  assign o_tx_done = done_q;

endmodule
